// File: rtl/mem_lsq_unit_pkg.sv
// mem_pkg: shared definitions for the load/store unit.
//   - 8-bit acceptor/result tag layout: {valid, type[3:0], id[2:0]}
//   - per-entry state encoding
//   - make_tag(): builds a tag from a valid flag and an entry id
package mem_pkg;

  localparam int         TAG_VALID_BIT = 7;
  localparam logic [3:0] TYPE_MEM      = 4'b1000;
  localparam int         ID_W          = 3;
  localparam int         CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } ent_state_e;

  function automatic logic [7:0] make_tag(input logic valid, input logic [ID_W-1:0] id);
    logic [7:0] t;
    t                = {1'b0, TYPE_MEM, id};
    t[TAG_VALID_BIT] = valid;
    return t;
  endfunction

endpackage

// File: rtl/mem_lsq_unit_if.sv
// mem_lsq_unit_if: dispatcher and CDB signals of the load/store unit.
//   Dispatcher side: rden, wren, addr_in, data_in -> unit;
//                    ready_for_instr, acceptor_tag <- unit.
//   CDB side:        cdb_grant -> unit;
//                    data_out_valid, data_out, reg_tag_out <- unit.
// Modports: master = dispatcher/CDB arbiter, slave = mem_lsq_unit.
interface mem_lsq_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              rden;
  logic              wren;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_for_instr;
  logic [7:0]        acceptor_tag;
  logic              cdb_grant;
  logic              data_out_valid;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        reg_tag_out;

  modport master (
    output rden, wren, addr_in, data_in, cdb_grant,
    input  ready_for_instr, acceptor_tag, data_out_valid, data_out, reg_tag_out
  );

  modport slave (
    input  rden, wren, addr_in, data_in, cdb_grant,
    output ready_for_instr, acceptor_tag, data_out_valid, data_out, reg_tag_out
  );
endinterface

// File: rtl/mem_lsq_unit_entry.sv
// mem_lsq_entry: one load-buffer entry (state, latency counter, address, data).
// Ports:
//   clk, reset_n      clock, async active-low reset
//   en_i              global enable; low holds everything
//   alloc_i           this entry accepts the current load
//   addr_i            memory index of the load being accepted
//   grant_i           this entry's presented result is taken by the CDB
//   mem_rdata_i       backing-memory word at addr_o
//   st_we_i/st_addr_i/st_data_i  store happening this cycle (for forwarding)
//   state_o, addr_o, data_o      entry state, latched index, captured data
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | free, may be allocated
// ST_WAIT | load accepted, counting towards LAT
// ST_DONE | data captured, waiting for a CDB grant
module mem_lsq_entry
  import mem_pkg::*;
#(
  parameter int LAT    = 8,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic              alloc_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic              grant_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              st_we_i,
  input  logic [MEM_AW-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  output ent_state_e        state_o,
  output logic [MEM_AW-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  ent_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (en_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (alloc_i) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
            addr_d  = addr_i;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            // A store landing on our index in the capture cycle wins over
            // the stale array contents.
            data_d  = (st_we_i && (st_addr_i == addr_q)) ? st_data_i : mem_rdata_i;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (grant_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_lsq_unit.sv
// mem_lsq_unit: load/store unit with a DEPTH-entry load buffer, a local
// word-addressed backing memory and a CDB result port.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   en             global enable; low freezes all state
//   lsq (slave)    dispatcher request/acceptor tag and CDB result/grant
// Stores write the memory immediately and never occupy an entry. Loads take
// the lowest free entry, wait LAT cycles, then present on the CDB.
// Build option MEM_LSQ_RR_ARB_EN: round-robin CDB selection starting at a
// pointer that moves past each granted id; otherwise lowest DONE id wins.
module mem_lsq_unit
  import mem_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int LAT    = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  mem_lsq_unit_if.slave  lsq
);

  ent_state_e        ent_state [DEPTH];
  logic [MEM_AW-1:0] ent_addr  [DEPTH];
  logic [DATA_W-1:0] ent_data  [DEPTH];
  logic [DATA_W-1:0] ent_rdata [DEPTH];

  logic [DATA_W-1:0] mem_q [2**MEM_AW];

  logic [7:0]        free_vec, done_vec;
  logic [ID_W-1:0]   alloc_id, sel_id;
  logic              any_free, any_done;
  logic              st_we, ld_accept, granted;
  logic [MEM_AW-1:0] idx_in;
  logic [DATA_W-1:0] sel_data;
  logic              unused_addr_hi;

  assign idx_in         = lsq.addr_in[MEM_AW-1:0];
  assign unused_addr_hi = ^lsq.addr_in[ADDR_W-1:MEM_AW];

  // A simultaneous rden+wren is a store only.
  assign st_we     = en & lsq.wren;
  assign ld_accept = en & lsq.rden & ~lsq.wren & any_free;
  assign granted   = en & lsq.cdb_grant & any_done;

  always_ff @(posedge clk) begin
    if (st_we) mem_q[idx_in] <= lsq.data_in;
  end

  always_comb begin
    free_vec = '0;
    done_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = (ent_state[i] == ST_IDLE);
      done_vec[i] = (ent_state[i] == ST_DONE);
    end
  end

  assign any_free = |free_vec;
  assign any_done = |done_vec;

  always_comb begin
    alloc_id = '0;
    for (int i = 7; i >= 0; i--) begin
      if (free_vec[i]) alloc_id = ID_W'(i);
    end
  end

`ifdef MEM_LSQ_RR_ARB_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W:0]   rr_idx;

  // Walk from the pointer downwards in offset so the nearest DONE entry at
  // or after the pointer is the last assignment, wrapping modulo DEPTH.
  always_comb begin
    sel_id = '0;
    rr_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rr_idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (rr_idx >= (ID_W + 1)'(DEPTH)) rr_idx = rr_idx - (ID_W + 1)'(DEPTH);
      if (done_vec[rr_idx[ID_W-1:0]]) sel_id = rr_idx[ID_W-1:0];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (granted) rr_ptr_d = (sel_id == ID_W'(DEPTH - 1)) ? '0 : sel_id + ID_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    sel_id = '0;
    for (int i = 7; i >= 0; i--) begin
      if (done_vec[i]) sel_id = ID_W'(i);
    end
  end
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ID_W'(i) == sel_id) sel_data = ent_data[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_rdata[g] = mem_q[ent_addr[g]];

    mem_lsq_entry #(
      .LAT    (LAT),
      .DATA_W (DATA_W),
      .MEM_AW (MEM_AW)
    ) u_entry (
      .clk         (clk),
      .reset_n     (reset_n),
      .en_i        (en),
      .alloc_i     (ld_accept && (alloc_id == ID_W'(g))),
      .addr_i      (idx_in),
      .grant_i     (granted && (sel_id == ID_W'(g))),
      .mem_rdata_i (ent_rdata[g]),
      .st_we_i     (st_we),
      .st_addr_i   (idx_in),
      .st_data_i   (lsq.data_in),
      .state_o     (ent_state[g]),
      .addr_o      (ent_addr[g]),
      .data_o      (ent_data[g])
    );
  end

  assign lsq.ready_for_instr = any_free;
  assign lsq.acceptor_tag    = make_tag(any_free, alloc_id);
  assign lsq.data_out_valid  = any_done;
  assign lsq.data_out        = any_done ? sel_data : '0;
  assign lsq.reg_tag_out     = any_done ? make_tag(1'b1, sel_id) : 8'h00;

endmodule

// File: tb/tb_mem_lsq_unit.sv
module tb_mem_lsq_unit;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic en      = 1'b0;

  always #5 clk = ~clk;

  mem_lsq_unit_if #(.DATA_W(32), .ADDR_W(32)) lsq ();

  mem_lsq_unit #(
    .DEPTH  (8),
    .LAT    (8),
    .DATA_W (32),
    .ADDR_W (32),
    .MEM_AW (6)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .lsq     (lsq.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    lsq.wren    = 1'b1;
    lsq.addr_in = a;
    lsq.data_in = d;
    tick();
    lsq.wren    = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    lsq.rden    = 1'b1;
    lsq.addr_in = a;
    tick();
    lsq.rden    = 1'b0;
  endtask

  // Scoreboard monitor: every CDB transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && en && lsq.cdb_grant && lsq.data_out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual data=%0h tag=%0h required none", lsq.data_out, lsq.reg_tag_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("cdb_data", 64'(lsq.data_out), 64'(mon_e.data));
        chk("cdb_tag", 64'(lsq.reg_tag_out), 64'(mon_e.tag));
      end
    end
  end

  initial begin
    lsq.rden = 1'b0; lsq.wren = 1'b0; lsq.addr_in = '0; lsq.data_in = '0; lsq.cdb_grant = 1'b0;

    // Reset values
    #12;
    chk("rst_ready", 64'(lsq.ready_for_instr), 64'd1);
    chk("rst_acceptor", 64'(lsq.acceptor_tag), 64'hC0);
    chk("rst_valid", 64'(lsq.data_out_valid), 64'd0);
    chk("rst_data", 64'(lsq.data_out), 64'd0);
    chk("rst_tag", 64'(lsq.reg_tag_out), 64'd0);
    reset_n = 1'b1;
    en      = 1'b1;
    tick();

    // Basic load latency
    store(32'd5, 32'hDEAD_BEEF);
    chk("t1_acceptor", 64'(lsq.acceptor_tag), 64'hC0);
    lsq.cdb_grant = 1'b1;
    sb_q.push_back('{data: 32'hDEAD_BEEF, tag: 8'hC0});
    load(32'd5);
    tick(6);
    chk("t1_valid_c7", 64'(lsq.data_out_valid), 64'd0);
    tick();
    chk("t1_valid_c8", 64'(lsq.data_out_valid), 64'd1);
    chk("t1_tag_c8", 64'(lsq.reg_tag_out), 64'hC0);
    chk("t1_acceptor_c8", 64'(lsq.acceptor_tag), 64'hC1);
    tick();
    chk("t1_valid_c9", 64'(lsq.data_out_valid), 64'd0);
    chk("t1_acceptor_c9", 64'(lsq.acceptor_tag), 64'hC0);
    lsq.cdb_grant = 1'b0;

    // Fill the buffer
    for (int i = 0; i < 8; i++) store(32'(10 + i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      chk("t2_acceptor", 64'(lsq.acceptor_tag), 64'(8'hC0 + 8'(i)));
      lsq.rden    = 1'b1;
      lsq.addr_in = 32'(10 + i);
      tick();
    end
    chk("t2_full_ready", 64'(lsq.ready_for_instr), 64'd0);
    chk("t2_full_acc7", 64'(lsq.acceptor_tag[7]), 64'd0);
    lsq.addr_in = 32'd20;
    tick();
    lsq.rden = 1'b0;
    chk("t2_ninth_ignored", 64'(lsq.ready_for_instr), 64'd0);
    tick(10);
    chk("t2_valid", 64'(lsq.data_out_valid), 64'd1);
    chk("t2_first_tag", 64'(lsq.reg_tag_out), 64'hC0);
    sb_q.push_back('{data: 32'hA000_0000, tag: 8'hC0});
    lsq.cdb_grant = 1'b1;
    tick();
    lsq.cdb_grant = 1'b0;
    chk("t2_freed_acceptor", 64'(lsq.acceptor_tag), 64'hC0);
    chk("t2_freed_ready", 64'(lsq.ready_for_instr), 64'd1);
    chk("t2_next_tag", 64'(lsq.reg_tag_out), 64'hC1);
    for (int i = 1; i < 8; i++) sb_q.push_back('{data: 32'hA000_0000 + 32'(i), tag: 8'hC0 + 8'(i)});
    lsq.cdb_grant = 1'b1;
    tick(7);
    lsq.cdb_grant = 1'b0;
    chk("t2_drained", 64'(lsq.data_out_valid), 64'd0);

    // Store hitting the capture cycle
    store(32'd3, 32'h0000_0111);
    chk("t3_acceptor", 64'(lsq.acceptor_tag), 64'hC0);
    load(32'd3);
    tick(6);
    chk("t3_valid_c7", 64'(lsq.data_out_valid), 64'd0);
    sb_q.push_back('{data: 32'h0000_0333, tag: 8'hC0});
    lsq.wren = 1'b1; lsq.addr_in = 32'd3; lsq.data_in = 32'h0000_0333;
    tick();
    lsq.wren = 1'b0;
    chk("t3_valid_c8", 64'(lsq.data_out_valid), 64'd1);
    lsq.cdb_grant = 1'b1;
    tick();
    lsq.cdb_grant = 1'b0;

    // rden and wren together
    chk("t4_ready_pre", 64'(lsq.ready_for_instr), 64'd1);
    lsq.rden = 1'b1; lsq.wren = 1'b1; lsq.addr_in = 32'd7; lsq.data_in = 32'h1234;
    tick();
    lsq.rden = 1'b0; lsq.wren = 1'b0;
    chk("t4_ready", 64'(lsq.ready_for_instr), 64'd1);
    chk("t4_acceptor", 64'(lsq.acceptor_tag), 64'hC0);
    tick(9);
    chk("t4_no_result", 64'(lsq.data_out_valid), 64'd0);
    sb_q.push_back('{data: 32'h1234, tag: 8'hC0});
    lsq.cdb_grant = 1'b1;
    load(32'd7);
    tick(7);
    chk("t4_valid", 64'(lsq.data_out_valid), 64'd1);
    tick();
    lsq.cdb_grant = 1'b0;

    // en low for 5 cycles mid-wait; a store under en=0 must not land
    store(32'd9, 32'h0000_9999);
    lsq.cdb_grant = 1'b1;
    sb_q.push_back('{data: 32'h0000_9999, tag: 8'hC0});
    load(32'd9);
    tick(2);
    en = 1'b0;
    lsq.wren = 1'b1; lsq.addr_in = 32'd9; lsq.data_in = 32'h0000_0BAD;
    tick();
    lsq.wren = 1'b0;
    chk("t5_acceptor_frozen", 64'(lsq.acceptor_tag), 64'hC1);
    tick(4);
    en = 1'b1;
    tick(4);
    chk("t5_valid_c12", 64'(lsq.data_out_valid), 64'd0);
    tick();
    chk("t5_valid_c13", 64'(lsq.data_out_valid), 64'd1);
    tick();
    lsq.cdb_grant = 1'b0;

    // Arbitration order
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) store(32'(20 + i), 32'(32'h20 + i));
    sb_q.push_back('{data: 32'h20, tag: 8'hC0});
    sb_q.push_back('{data: 32'h21, tag: 8'hC1});
    sb_q.push_back('{data: 32'h22, tag: 8'hC2});
    for (int i = 0; i < 3; i++) load(32'(20 + i));
    tick(10);
    lsq.cdb_grant = 1'b1;
    tick(3);
    lsq.cdb_grant = 1'b0;
    chk("t6_a_drained", 64'(lsq.data_out_valid), 64'd0);
    for (int i = 0; i < 3; i++) load(32'(20 + i));
    tick(10);
    sb_q.push_back('{data: 32'h20, tag: 8'hC0});
    lsq.cdb_grant = 1'b1;
    tick();
    lsq.cdb_grant = 1'b0;
    chk("t6_b_acceptor", 64'(lsq.acceptor_tag), 64'hC0);
    load(32'd23);
    tick(9);
`ifdef MEM_LSQ_RR_ARB_EN
    sb_q.push_back('{data: 32'h21, tag: 8'hC1});
    sb_q.push_back('{data: 32'h22, tag: 8'hC2});
    sb_q.push_back('{data: 32'h23, tag: 8'hC0});
`else
    sb_q.push_back('{data: 32'h23, tag: 8'hC0});
    sb_q.push_back('{data: 32'h21, tag: 8'hC1});
    sb_q.push_back('{data: 32'h22, tag: 8'hC2});
`endif
    lsq.cdb_grant = 1'b1;
    tick(3);
    lsq.cdb_grant = 1'b0;
    chk("t6_b_drained", 64'(lsq.data_out_valid), 64'd0);

    // Asynchronous reset with loads in flight
    for (int i = 0; i < 3; i++) load(32'(20 + i));
    tick(5);
    chk("t7_valid_before", 64'(lsq.data_out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_valid_async", 64'(lsq.data_out_valid), 64'd0);
    chk("t7_data_async", 64'(lsq.data_out), 64'd0);
    chk("t7_tag_async", 64'(lsq.reg_tag_out), 64'd0);
    chk("t7_ready_async", 64'(lsq.ready_for_instr), 64'd1);
    chk("t7_acceptor_async", 64'(lsq.acceptor_tag), 64'hC0);
    tick();
    reset_n = 1'b1;
    lsq.cdb_grant = 1'b1;
    tick(12);
    chk("t7_no_stale", 64'(lsq.data_out_valid), 64'd0);
    lsq.cdb_grant = 1'b0;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
